// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and widths for the frame-buffer VRAM arbiter
package fb_pkg;

  localparam int PIX_W   = 12;
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;
  localparam int VRAM_AW = 20;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_e;

  // The buffer select bit sits above row/col so each buffer is one contiguous half.
  function automatic logic [VRAM_AW-1:0] vram_addr(input logic            buf_sel,
                                                   input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return {buf_sel, row, col};
  endfunction

endpackage

// File: rtl/fb_vram_arbiter_if.sv
// rtl/fb_vram_arbiter_if.sv - VGA, renderer, swap and VRAM signals of the arbiter
// slave is the arbiter's view; master is the surrounding system's view.
interface fb_vram_arbiter_if;
  import fb_pkg::*;

  logic [ROW_W-1:0]   vga_row;
  logic [COL_W-1:0]   vga_col;
  logic               vga_rdn;
  logic               vga_vs;
  logic [PIX_W-1:0]   vga_din;
  logic               wr_valid;
  logic               wr_ready;
  logic [ROW_W-1:0]   wr_row;
  logic [COL_W-1:0]   wr_col;
  logic [PIX_W-1:0]   wr_data;
  logic               swap_req;
  logic               swap_done;
  logic               front_sel;
  logic [CNT_W-1:0]   frame_cnt;
  logic [VRAM_AW-1:0] mem_addr;
  logic               mem_we;
  logic [PIX_W-1:0]   mem_wdata;
  logic [PIX_W-1:0]   mem_rdata;

  modport slave (
    input  vga_row, vga_col, vga_rdn, vga_vs, wr_valid, wr_row, wr_col, wr_data,
           swap_req, mem_rdata,
    output vga_din, wr_ready, swap_done, front_sel, frame_cnt, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_row, vga_col, vga_rdn, vga_vs, wr_valid, wr_row, wr_col, wr_data,
           swap_req, mem_rdata,
    input  vga_din, wr_ready, swap_done, front_sel, frame_cnt, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous FIFO holding renderer writes until VRAM is idle
// Head entry is visible on dout whenever the FIFO is non-empty.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  wr_entry_t     mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/fb_vram_arbiter.sv
// rtl/fb_vram_arbiter.sv - single-port VRAM arbiter with double-buffer swap at vsync
// Scan-out owns VRAM whenever vga_rdn is low; queued renderer writes drain otherwise.
module fb_vram_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  fb_vram_arbiter_if.slave  bus
);

  logic             vs_q;
  logic             vs_start;
  swap_state_e      state_q, state_d;
  logic             front_q, front_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] fcnt_q;

  wr_entry_t        push_entry, head;
  logic             fifo_full, fifo_empty, push, pop;
  logic             wr_ready;

  logic [VRAM_AW-1:0] mem_addr;
  logic               mem_we;
  logic [PIX_W-1:0]   mem_wdata;

  assign vs_start   = vs_q & ~bus.vga_vs;
  assign wr_ready   = ~fifo_full & (state_q == IDLE);
  assign push       = bus.wr_valid & wr_ready;
  assign pop        = bus.vga_rdn & ~fifo_empty;
  assign push_entry = '{row: bus.wr_row, col: bus.wr_col, data: bus.wr_data};

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!bus.vga_rdn) begin
      mem_addr = vram_addr(front_q, bus.vga_row, bus.vga_col);
    end else if (!fifo_empty) begin
      mem_we    = 1'b1;
      mem_addr  = vram_addr(~front_q, head.row, head.col);
      mem_wdata = head.data;
    end
  end

  // A swap needs every queued write already in the back buffer, else wait a frame.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.swap_req) state_d = PEND;
      PEND: if (vs_start && fifo_empty) begin
        front_d = ~front_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q    <= 1'b1;
      state_q <= IDLE;
      front_q <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      vs_q    <= bus.vga_vs;
      state_q <= state_d;
      front_q <= front_d;
      done_q  <= done_d;
      if (vs_start) fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign bus.vga_din   = bus.mem_rdata;
  assign bus.wr_ready  = wr_ready;
  assign bus.swap_done = done_q;
  assign bus.front_sel = front_q;
  assign bus.frame_cnt = fcnt_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_fb_vram_arbiter.sv
// tb/tb_fb_vram_arbiter.sv - self-checking bench for fb_vram_arbiter
// Directed scenarios then random traffic, all against a queue-based frame-buffer model.
module tb_fb_vram_arbiter;

  logic clk;
  logic rstn;

  fb_vram_arbiter_if bus ();

  fb_vram_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] dflt(input logic [19:0] a);
    return a[11:0] ^ {a[19:12], a[3:0]};
  endfunction

  // VRAM macro: synchronous single port, one cycle read latency.
  logic [11:0] vram [logic [19:0]];
  always @(posedge clk) begin
    logic [11:0] rd;
    rd = vram.exists(bus.mem_addr) ? vram[bus.mem_addr] : dflt(bus.mem_addr);
    if (bus.mem_we) vram[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= rd;
  end

  typedef struct {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] data;
  } ent_t;

  ent_t        wq[$];
  bit          m_front, m_pend, m_vsprev;
  int          m_fcnt;
  logic [11:0] mm [logic [19:0]];

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] obs_addr;
  logic        obs_we, obs_ready, obs_done, obs_front;

  function automatic logic [11:0] mm_rd(input logic [19:0] a);
    return mm.exists(a) ? mm[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_front  = 1'b0;
    m_pend   = 1'b0;
    m_fcnt   = 0;
    m_vsprev = 1'b1;
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic cycle(input bit rdn, input bit vs, input bit wv, input bit sr,
                       input logic [8:0] row, input logic [9:0] col,
                       input logic [8:0] wrow, input logic [9:0] wcol, input logic [11:0] wd);
    bit          vs_start, swap_now, e_we, e_ready;
    logic [19:0] e_addr;
    logic [11:0] e_wdata, e_din;
    ent_t        e;
    bus.vga_rdn  = rdn;
    bus.vga_vs   = vs;
    bus.wr_valid = wv;
    bus.swap_req = sr;
    bus.vga_row  = row;
    bus.vga_col  = col;
    bus.wr_row   = wrow;
    bus.wr_col   = wcol;
    bus.wr_data  = wd;
    #2;
    e_ready = (wq.size() < 4) && !m_pend;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    if (!rdn) begin
      e_addr = {m_front, row, col};
    end else if (wq.size() > 0) begin
      e_we    = 1'b1;
      e_addr  = {~m_front, wq[0].row, wq[0].col};
      e_wdata = wq[0].data;
    end
    obs_addr  = bus.mem_addr;
    obs_we    = bus.mem_we;
    obs_ready = bus.wr_ready;
    check("wr_ready", 32'(obs_ready), 32'(e_ready));
    check("mem_we", 32'(obs_we), 32'(e_we));
    check("mem_addr", 32'(obs_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    e_din = mm_rd(e_addr);

    vs_start = m_vsprev && !vs;
    swap_now = m_pend && vs_start && (wq.size() == 0);
    if (e_we) begin
      mm[e_addr] = e_wdata;
      void'(wq.pop_front());
    end
    if (wv && e_ready) begin
      e.row = wrow; e.col = wcol; e.data = wd;
      wq.push_back(e);
    end
    if (swap_now) begin
      m_front = ~m_front;
      m_pend  = 1'b0;
    end else if (sr) begin
      m_pend = 1'b1;
    end
    if (vs_start) m_fcnt = (m_fcnt + 1) % 256;
    m_vsprev = vs;

    @(posedge clk);
    #1;
    obs_done  = bus.swap_done;
    obs_front = bus.front_sel;
    check("swap_done", 32'(obs_done), 32'(swap_now));
    check("front_sel", 32'(obs_front), 32'(m_front));
    check("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
    if (!rdn) check("vga_din", 32'(bus.vga_din), 32'(e_din));
  endtask

  task automatic idle(input bit rdn, input bit vs, input bit sr);
    cycle(rdn, vs, 1'b0, sr, 9'd0, 10'd0, 9'd0, 10'd0, 12'd0);
  endtask

  task automatic apply_reset();
    bus.vga_rdn  = 1'b1;
    bus.vga_vs   = 1'b1;
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_front", 32'(bus.front_sel), 32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    check("rst_done", 32'(bus.swap_done), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    int wes, dones;
    rstn          = 1'b0;
    bus.vga_row   = '0;
    bus.vga_col   = '0;
    bus.wr_row    = '0;
    bus.wr_col    = '0;
    bus.wr_data   = '0;
    apply_reset();

    vram[20'h01407] = 12'hABC;
    mm[20'h01407]   = 12'hABC;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'd5, 10'd7, 9'd0, 10'd0, 12'd0);
    check("t1_addr", 32'(obs_addr), 32'h01407);
    check("t1_din", 32'(bus.vga_din), 32'hABC);

    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 9'd10, 10'(i), 9'(i + 1), 10'd0, 12'($urandom));
    idle(1'b0, 1'b1, 1'b0);
    check("t2_full_ready", 32'(obs_ready), 32'd0);
    wes = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b1, 1'b0);
      wes += int'(obs_we);
      if (i == 0) check("t2_buf1", 32'(obs_addr[19]), 32'd1);
      if (i == 1) check("t2_ready_after_pop", 32'(obs_ready), 32'd1);
    end
    check("t2_writes", 32'(wes), 32'd4);

    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    check("t3_done", 32'(obs_done), 32'd1);
    check("t3_front", 32'(obs_front), 32'd1);
    idle(1'b1, 1'b1, 1'b0);
    check("t3_done_pulse", 32'(obs_done), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'd2, 10'd0, 9'd0, 10'd0, 12'd0);
    check("t3_rd_buf", 32'(obs_addr[19]), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 9'd3, 10'd3, 9'd7, 10'd9, 12'h5A5);
    idle(1'b1, 1'b1, 1'b0);
    check("t3_wr_buf", 32'(obs_addr[19]), 32'd0);

    cycle(1'b0, 1'b1, 1'b1, 1'b1, 9'd1, 10'd1, 9'd4, 10'd4, 12'h123);
    idle(1'b0, 1'b1, 1'b0);
    check("t4_ready_pend", 32'(obs_ready), 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    check("t4_no_swap", 32'(obs_done), 32'd0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    check("t4_ready_drain", 32'(obs_ready), 32'd0);
    idle(1'b1, 1'b0, 1'b0);
    check("t4_done", 32'(obs_done), 32'd1);
    check("t4_front", 32'(obs_front), 32'd0);
    idle(1'b1, 1'b1, 1'b0);
    check("t4_ready_idle", 32'(obs_ready), 32'd1);

    idle(1'b1, 1'b0, 1'b1);
    check("t5_coincident", 32'(obs_done), 32'd0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    dones = 0;
    idle(1'b1, 1'b0, 1'b0);
    dones += int'(obs_done);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1, 1'b0);
      dones += int'(obs_done);
    end
    check("t5_one_swap", 32'(dones), 32'd1);

    apply_reset();
    for (int i = 0; i < 256; i++) begin
      idle(1'b1, 1'b0, 1'b0);
      if (i == 254) check("t6_cnt_255", 32'(bus.frame_cnt), 32'd255);
      idle(1'b1, 1'b1, 1'b0);
    end
    check("t6_wrap", 32'(bus.frame_cnt), 32'd0);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 9'd6, 10'd6, 12'h777);
    check("t6_pre_front", 32'(bus.front_sel), 32'd1);
    apply_reset();
    check("t6_front", 32'(bus.front_sel), 32'd0);
    idle(1'b1, 1'b1, 1'b0);
    check("t6_fifo_empty", 32'(obs_we), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) == 0, (i % 50) < 45, ($urandom % 2) == 0, ($urandom % 25) == 0,
            9'($urandom_range(0, 3)), 10'($urandom_range(0, 7)),
            9'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
